ita_output_buffer: RTL and testbench

Downstream output stage of the activation/requantization datapath. It tracks which cycles carry valid results through the fixed activation pipeline latency and captures those N-lane 8-bit result vectors, with a tile-end marker, into a small FIFO. It presents them to the output streamer over a valid/ready handshake. It returns a credit-based stall so upstream never issues more results than the buffer can hold.

---
 rtl/ita_output_buffer.sv | 124 ++++++++++++
 tb/tb_ita_output_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_output_buffer.sv
// Output stage of the activation/requantization datapath: aligns issued results
// through the activation latency, buffers them in a small FIFO and returns credit-based stall.
module ita_output_buffer #(
   parameter int N     = 16,
   parameter int WI    = 8,
   parameter int DEPTH = 4,
   parameter int LAT   = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            calc_en_i,
   input  logic            last_i,
   input  logic [N*WI-1:0] data_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [N*WI-1:0] data_o,
   output logic            last_o,
   output logic            stall_o,
   output logic            overflow_o,
   output logic [15:0]     tile_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + LAT + 1);

   logic [LAT-1:0]  dly_v;
   logic [LAT-1:0]  dly_last;
   logic            wr_v;
   logic            wr_last;
   logic            rd;
   logic            wr;
   logic [N*WI-1:0] mem [DEPTH];
   logic [DEPTH-1:0] mem_last;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   pending;

   assign wr_v    = dly_v[LAT-1];
   assign wr_last = dly_last[LAT-1];
   assign valid_o = (count != '0);
   assign rd      = valid_o & ready_i;
   assign wr      = wr_v & ((count != (AW+1)'(DEPTH)) | rd);
   assign data_o  = mem[rd_ptr];
   assign last_o  = mem_last[rd_ptr];

   // Credits already spent: stored entries plus issues still travelling the delay line.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + CW'(dly_v[i]);
      end
      pending = CW'(count) + inflight;
   end

   assign stall_o = (pending >= CW'(DEPTH));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dly_v    <= '0;
         dly_last <= '0;
      end else if (clear_i) begin
         dly_v    <= '0;
         dly_last <= '0;
      end else begin
         dly_v[0]    <= calc_en_i;
         dly_last[0] <= last_i;
         for (int i = 1; i < LAT; i++) begin
            dly_v[i]    <= dly_v[i-1];
            dly_last[i] <= dly_last[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
         tile_cnt_o <= '0;
      end else if (clear_i) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
         tile_cnt_o <= '0;
      end else begin
         if (rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A result that finds the FIFO full with no read in the same cycle is lost.
         if (wr_v && !wr) begin
            overflow_o <= 1'b1;
         end
         if (rd && last_o) begin
            tile_cnt_o <= tile_cnt_o + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         mem_last <= '0;
      end else if (wr && !clear_i) begin
         mem[wr_ptr]      <= data_i;
         mem_last[wr_ptr] <= wr_last;
      end
   end

endmodule

// File: tb/tb_ita_output_buffer.sv
// Scoreboard bench for ita_output_buffer: a queue-level model of the delay line and FIFO
// predicts every output; a monitor compares on each falling edge.
module tb_ita_output_buffer;

   localparam int N     = 16;
   localparam int WI    = 8;
   localparam int DEPTH = 4;
   localparam int LAT   = 3;
   localparam int W     = N * WI;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           due;
   } beat_t;

   logic         clk_i     = 1'b0;
   logic         rst_ni    = 1'b0;
   logic         clear_i   = 1'b0;
   logic         calc_en_i = 1'b0;
   logic         last_i    = 1'b0;
   logic [W-1:0] data_i    = '0;
   logic         ready_i   = 1'b0;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         last_o;
   logic         stall_o;
   logic         overflow_o;
   logic [15:0]  tile_cnt_o;

   int           checks     = 0;
   int           errors     = 0;
   int           cycle      = 0;
   int           issued     = 0;
   int           valid_seen = 0;
   bit           mon_en     = 1'b0;
   bit           exp_ovf    = 1'b0;
   logic [15:0]  exp_tile   = '0;
   logic [W-1:0] issue_data = '0;
   beat_t        issue_q[$];
   beat_t        model_q[$];

   ita_output_buffer #(.N(N), .WI(WI), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .calc_en_i  (calc_en_i),
      .last_i     (last_i),
      .data_i     (data_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .last_o     (last_o),
      .stall_o    (stall_o),
      .overflow_o (overflow_o),
      .tile_cnt_o (tile_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] randWord();
      logic [W-1:0] r = '0;
      for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference model: issued results become due LAT cycles later; a due result enters the
   // expected FIFO when there is room (or a read frees a slot), otherwise it is lost.
   always @(posedge clk_i) begin
      beat_t b;
      int    sz;
      bit    rd;
      if (!rst_ni || clear_i) begin
         issue_q.delete();
         model_q.delete();
         exp_ovf  = 1'b0;
         exp_tile = '0;
      end else begin
         sz = model_q.size();
         rd = (sz != 0) && ready_i;
         if (rd) begin
            if (model_q[0].last) exp_tile = exp_tile + 16'd1;
            void'(model_q.pop_front());
         end
         if (issue_q.size() != 0 && issue_q[0].due == cycle) begin
            b = issue_q.pop_front();
            if (sz < DEPTH || rd) model_q.push_back(b);
            else exp_ovf = 1'b1;
         end
         if (calc_en_i) begin
            b.data = issue_data;
            b.last = last_i;
            b.due  = cycle + LAT;
            issue_q.push_back(b);
         end
      end
      cycle++;
   end

   always @(negedge rst_ni) begin
      issue_q.delete();
      model_q.delete();
      exp_ovf  = 1'b0;
      exp_tile = '0;
   end

   // Upstream datapath: presents each result exactly on its due cycle, junk otherwise.
   always @(negedge clk_i) begin
      if (issue_q.size() != 0 && issue_q[0].due == cycle) data_i = issue_q[0].data;
      else data_i = randWord();
   end

   always @(negedge clk_i) begin
      if (mon_en && rst_ni) begin
         checkOutput("valid_o", W'(valid_o), W'(model_q.size() != 0));
         if (model_q.size() != 0) begin
            checkOutput("data_o", data_o, model_q[0].data);
            checkOutput("last_o", W'(last_o), W'(model_q[0].last));
         end
         checkOutput("stall_o", W'(stall_o), W'((model_q.size() + issue_q.size()) >= DEPTH));
         checkOutput("overflow_o", W'(overflow_o), W'(exp_ovf));
         checkOutput("tile_cnt_o", W'(tile_cnt_o), W'(exp_tile));
         if (valid_o) valid_seen++;
      end
   end

   task automatic cycleDrive(input bit iss, input bit lst, input bit rdy, input bit obey,
                             input logic [W-1:0] d);
      @(negedge clk_i);
      clear_i    = 1'b0;
      ready_i    = rdy;
      calc_en_i  = iss && (!obey || !stall_o);
      last_i     = lst;
      issue_data = d;
      if (calc_en_i) issued++;
   endtask

   task automatic applyStimulus(input int ncyc, input int iss_pct, input int rdy_pct, input bit obey);
      for (int i = 0; i < ncyc; i++) begin
         cycleDrive($urandom_range(99) < iss_pct, (issued % 4) == 3,
                    $urandom_range(99) < rdy_pct, obey, randWord());
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " valid_o"}, W'(valid_o), '0);
      checkOutput({tag, " data_o"}, data_o, '0);
      checkOutput({tag, " last_o"}, W'(last_o), '0);
      checkOutput({tag, " stall_o"}, W'(stall_o), '0);
      checkOutput({tag, " overflow_o"}, W'(overflow_o), '0);
      checkOutput({tag, " tile_cnt_o"}, W'(tile_cnt_o), '0);
   endtask

   initial begin
      logic [W-1:0] d;
      int base;

      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      checkResetValues("reset");
      rst_ni = 1'b1;
      mon_en = 1'b1;

      // Single beat with lane k = k and a tile-end marker.
      for (int k = 0; k < N; k++) d[k*WI +: WI] = WI'(k);
      valid_seen = 0;
      cycleDrive(1, 1, 1, 1, d);
      repeat (LAT + 4) cycleDrive(0, 0, 1, 1, '0);
      checkOutput("single valid cycles", W'(valid_seen), W'(1));
      checkOutput("single tile_cnt", W'(tile_cnt_o), W'(1));

      // Fill under backpressure while honouring stall_o.
      base = issued;
      repeat (10) cycleDrive(1, 0, 0, 1, randWord());
      cycleDrive(0, 0, 0, 1, '0);
      checkOutput("fill accepted issues", W'(issued - base), W'(DEPTH));
      checkOutput("fill stall_o", W'(stall_o), W'(1));
      repeat (8) cycleDrive(0, 0, 1, 1, '0);
      checkOutput("drain stall_o", W'(stall_o), W'(0));
      checkOutput("drain valid_o", W'(valid_o), W'(0));

      // Full FIFO with a read and a write landing in the same cycle.
      repeat (DEPTH) cycleDrive(1, 0, 0, 0, randWord());
      repeat (LAT) cycleDrive(0, 0, 0, 0, '0);
      cycleDrive(1, 1, 0, 0, randWord());
      repeat (LAT - 1) cycleDrive(0, 0, 0, 0, '0);
      cycleDrive(0, 0, 1, 0, '0);
      cycleDrive(0, 0, 0, 0, '0);
      checkOutput("full rd+wr overflow_o", W'(overflow_o), W'(0));
      checkOutput("full rd+wr valid_o", W'(valid_o), W'(1));

      // Forced overflow ignoring stall_o, then flush with a simultaneous (ignored) issue.
      cycleDrive(1, 0, 0, 0, randWord());
      repeat (LAT + 2) cycleDrive(0, 0, 0, 0, '0);
      checkOutput("forced overflow_o", W'(overflow_o), W'(1));
      @(negedge clk_i);
      clear_i    = 1'b1;
      calc_en_i  = 1'b1;
      issue_data = randWord();
      cycleDrive(0, 0, 1, 0, '0);
      checkOutput("clear overflow_o", W'(overflow_o), W'(0));
      checkOutput("clear valid_o", W'(valid_o), W'(0));
      repeat (LAT + 3) cycleDrive(0, 0, 1, 0, '0);

      // Long random stream honouring stall_o, then a stretch that ignores it.
      applyStimulus(3000, 70, 60, 1);
      repeat (LAT + DEPTH + 4) cycleDrive(0, 0, 1, 1, '0);
      checkOutput("stream overflow_o", W'(overflow_o), W'(0));
      checkOutput("stream drained valid_o", W'(valid_o), W'(0));
      applyStimulus(600, 80, 40, 0);
      repeat (LAT + DEPTH + 4) cycleDrive(0, 0, 1, 1, '0);
      @(negedge clk_i);
      clear_i   = 1'b1;
      calc_en_i = 1'b0;
      cycleDrive(0, 0, 0, 0, '0);

      // Asynchronous reset with three entries stored and two in flight.
      repeat (5) cycleDrive(1, 1, 0, 0, randWord());
      repeat (2) cycleDrive(0, 0, 0, 0, '0);
      checkOutput("pre-reset valid_o", W'(valid_o), W'(1));
      checkOutput("pre-reset stall_o", W'(stall_o), W'(1));
      #1 rst_ni = 1'b0;
      #1 checkResetValues("async reset");
      @(negedge clk_i);
      rst_ni     = 1'b1;
      valid_seen = 0;
      repeat (LAT + 4) cycleDrive(0, 0, 1, 1, '0);
      checkOutput("post-reset stale beats", W'(valid_seen), W'(0));

      applyStimulus(200, 50, 50, 1);
      repeat (LAT + DEPTH + 4) cycleDrive(0, 0, 1, 1, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
